// File: rtl/pong_pkg.sv
// Shared types and default constants for the pong game engine.
// Speed-up on return is enabled by defining PONG_SPEEDUP_EN.
package pong_pkg;

  localparam int unsigned PERIOD_W        = 4;
  localparam int unsigned DEF_N_LEDS      = 8;
  localparam int unsigned DEF_SCORE_W     = 4;
  localparam int unsigned DEF_WIN_SCORE   = 15;
  localparam int unsigned DEF_INIT_PERIOD = 4;

  typedef enum logic [1:0] {
    ST_SERVE    = 2'd0,
    ST_MOVE_UP  = 2'd1,
    ST_MOVE_DN  = 2'd2,
    ST_GAMEOVER = 2'd3
  } state_t;

endpackage

// File: rtl/pong_step_timer.sv
// Ball step timer: counts ticks against the current period and strobes a step.
// With PONG_SPEEDUP_EN defined, each return shortens the period down to 1.
module pong_step_timer
  import pong_pkg::*;
#(
  parameter int unsigned INIT_PERIOD = DEF_INIT_PERIOD
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_run,
  input  logic i_ret,
  output logic o_step_c
);

  localparam logic [PERIOD_W-1:0] INIT_P = PERIOD_W'(INIT_PERIOD);

  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] r_period;
  logic                w_hit;

  assign w_hit    = (r_cnt == (r_period - PERIOD_W'(1)));
  assign o_step_c = i_tick & i_run & w_hit;

  // Outside a rally the timer idles cleared with the serve period restored.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_period <= INIT_P;
    end else if (!i_run) begin
      r_cnt    <= '0;
      r_period <= INIT_P;
    end else if (i_ret) begin
      r_cnt <= '0;
`ifdef PONG_SPEEDUP_EN
      if (r_period > PERIOD_W'(1)) r_period <= r_period - PERIOD_W'(1);
`endif
    end else if (i_tick) begin
      r_cnt <= w_hit ? '0 : r_cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/pong_engine.sv
// Two-player LED pong: serve, rally, fault/miss scoring and game-over.
// Optional return speed-up is enabled by defining PONG_SPEEDUP_EN.
module pong_engine
  import pong_pkg::*;
#(
  parameter int unsigned N_LEDS      = DEF_N_LEDS,
  parameter int unsigned SCORE_W     = DEF_SCORE_W,
  parameter int unsigned WIN_SCORE   = DEF_WIN_SCORE,
  parameter int unsigned INIT_PERIOD = DEF_INIT_PERIOD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               p0,
  input  logic               p1,
  output logic [N_LEDS-1:0]  leds,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic               serve_side,
  output logic               game_over,
  output logic               winner
);

  localparam int unsigned        POS_W   = $clog2(N_LEDS);
  localparam logic [POS_W-1:0]   POS_MAX = POS_W'(N_LEDS - 1);
  localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);

  state_t             r_state, w_state_nxt;
  logic [POS_W-1:0]   r_pos, w_pos_nxt;
  logic [N_LEDS-1:0]  r_leds;
  logic [SCORE_W-1:0] r_score0, r_score1, w_score0_nxt, w_score1_nxt;
  logic               r_serve, w_serve_nxt;
  logic               r_go, w_go_nxt;
  logic               r_winner, w_winner_nxt;
  logic               r_f0, r_f1, w_f0, w_f1;
  logic               w_run, w_ret, w_point, w_scorer, w_step;

  // A press on the deciding cycle itself counts alongside the sticky flag.
  assign w_f0  = r_f0 | p0;
  assign w_f1  = r_f1 | p1;
  assign w_run = (r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DN);

  pong_step_timer #(
    .INIT_PERIOD(INIT_PERIOD)
  ) u_timer (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_tick   (tick),
    .i_run    (w_run),
    .i_ret    (w_ret),
    .o_step_c (w_step)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_pos_nxt    = r_pos;
    w_score0_nxt = r_score0;
    w_score1_nxt = r_score1;
    w_serve_nxt  = r_serve;
    w_go_nxt     = r_go;
    w_winner_nxt = r_winner;
    w_ret        = 1'b0;
    w_point      = 1'b0;
    w_scorer     = 1'b0;
    case (r_state)
      ST_SERVE: begin
        if (tick && (r_serve ? w_f1 : w_f0))
          w_state_nxt = r_serve ? ST_MOVE_DN : ST_MOVE_UP;
      end
      ST_MOVE_UP: begin
        if (tick) begin
          if (w_f1) begin
            if (r_pos == POS_MAX) begin
              w_ret       = 1'b1;
              w_state_nxt = ST_MOVE_DN;
            end else begin
              w_point = 1'b1;
            end
          end else if (w_step) begin
            if (r_pos == POS_MAX) w_point = 1'b1;
            else                  w_pos_nxt = r_pos + POS_W'(1);
          end
        end
      end
      ST_MOVE_DN: begin
        w_scorer = 1'b1;
        if (tick) begin
          if (w_f0) begin
            if (r_pos == '0) begin
              w_ret       = 1'b1;
              w_state_nxt = ST_MOVE_UP;
            end else begin
              w_point = 1'b1;
            end
          end else if (w_step) begin
            if (r_pos == '0) w_point = 1'b1;
            else             w_pos_nxt = r_pos - POS_W'(1);
          end
        end
      end
      default: ;
    endcase

    // Point: scorer advances; the loser serves from their own end.
    if (w_point) begin
      if (w_scorer) w_score1_nxt = r_score1 + SCORE_W'(1);
      else          w_score0_nxt = r_score0 + SCORE_W'(1);
      if ((w_scorer ? w_score1_nxt : w_score0_nxt) == WIN) begin
        w_state_nxt  = ST_GAMEOVER;
        w_go_nxt     = 1'b1;
        w_winner_nxt = w_scorer;
      end else begin
        w_state_nxt = ST_SERVE;
        w_serve_nxt = ~w_scorer;
        w_pos_nxt   = w_scorer ? '0 : POS_MAX;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_SERVE;
      r_pos    <= '0;
      r_leds   <= N_LEDS'(1);
      r_score0 <= '0;
      r_score1 <= '0;
      r_serve  <= 1'b0;
      r_go     <= 1'b0;
      r_winner <= 1'b0;
      r_f0     <= 1'b0;
      r_f1     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pos    <= w_pos_nxt;
      r_leds   <= (w_state_nxt == ST_GAMEOVER) ? {N_LEDS{1'b1}}
                                               : (N_LEDS'(1) << w_pos_nxt);
      r_score0 <= w_score0_nxt;
      r_score1 <= w_score1_nxt;
      r_serve  <= w_serve_nxt;
      r_go     <= w_go_nxt;
      r_winner <= w_winner_nxt;
      r_f0     <= tick ? 1'b0 : w_f0;
      r_f1     <= tick ? 1'b0 : w_f1;
    end
  end

  assign leds       = r_leds;
  assign score0     = r_score0;
  assign score1     = r_score1;
  assign serve_side = r_serve;
  assign game_over  = r_go;
  assign winner     = r_winner;

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: default 8-LED game plus a 16-LED, first-to-3 game.
module tb_pong_engine;

`ifdef PONG_SPEEDUP_EN
  localparam int P1 = 3;
  localparam int P2 = 2;
`else
  localparam int P1 = 4;
  localparam int P2 = 4;
`endif

  logic        clk = 1'b0;
  logic        reset, tick, p0, p1;
  logic [7:0]  leds;
  logic [3:0]  score0, score1;
  logic        serve_side, game_over, winner;

  logic        reset_b, p0_b, p1_b;
  logic [15:0] leds_b;
  logic [3:0]  score0_b, score1_b;
  logic        serve_b, go_b, win_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pong_engine u_dut (
    .clk(clk), .reset(reset), .tick(tick), .p0(p0), .p1(p1),
    .leds(leds), .score0(score0), .score1(score1),
    .serve_side(serve_side), .game_over(game_over), .winner(winner)
  );

  pong_engine #(.N_LEDS(16), .WIN_SCORE(3)) u_dut16 (
    .clk(clk), .reset(reset_b), .tick(1'b1), .p0(p0_b), .p1(p1_b),
    .leds(leds_b), .score0(score0_b), .score1(score1_b),
    .serve_side(serve_b), .game_over(go_b), .winner(win_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_a(input logic a, input logic b);
    p0 = a; p1 = b;
    @(negedge clk);
    p0 = 1'b0; p1 = 1'b0;
  endtask

  task automatic press_b(input logic a, input logic b);
    p0_b = a; p1_b = b;
    @(negedge clk);
    p0_b = 1'b0; p1_b = 1'b0;
  endtask

  // p1 serves, p0 returns at bit 0, p1 presses early: point to p0.
  task automatic p0_point_a();
    press_a(1'b0, 1'b1);
    cyc(28);
    press_a(1'b1, 1'b0);
    press_a(1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; reset_b = 1'b1; tick = 1'b1;
    p0 = 1'b0; p1 = 1'b0; p0_b = 1'b0; p1_b = 1'b0;
    cyc(2);
    reset = 1'b0; reset_b = 1'b0;
    cyc(1);
    check("rst_leds",   32'(leds), 32'h01);
    check("rst_score0", 32'(score0), 0);
    check("rst_score1", 32'(score1), 0);
    check("rst_serve",  32'(serve_side), 0);
    check("rst_go",     32'({game_over, winner}), 0);

    // Serve by p0, p1 never presses: miss at bit 7.
    press_a(1'b1, 1'b0);
    cyc(27);  check("up_bit6",  32'(leds), 32'h40);
    cyc(1);   check("up_bit7",  32'(leds), 32'h80);
    cyc(3);   check("pre_miss", 32'(score0), 0);
    cyc(1);   check("miss_s0",  32'(score0), 1);
    check("miss_serve", 32'(serve_side), 1);
    check("miss_leds",  32'(leds), 32'h80);

    // Rally: p1 serves, p0 returns at bit 0, p1 returns at bit 7.
    press_a(1'b0, 1'b1);
    cyc(28);  check("dn_bit0", 32'(leds), 32'h01);
    press_a(1'b1, 1'b0);
    check("ret0_hold", 32'(leds), 32'h01);
    cyc(P1);  check("ret0_bit1", 32'(leds), 32'h02);
    press_a(1'b1, 1'b0);
    cyc(6*P1-2); check("p1_bit6", 32'(leds), 32'h40);
    cyc(1);      check("p1_bit7", 32'(leds), 32'h80);
    check("nonrecv_s", 32'({score0, score1}), 32'h10);
    press_a(1'b1, 1'b1);
    cyc(P2-1); check("ret7_hold", 32'(leds), 32'h80);
    cyc(1);    check("p2_bit6",   32'(leds), 32'h40);
    cyc(6*P2); check("p2_bit0",   32'(leds), 32'h01);
    check("rally_s", 32'({score0, score1}), 32'h10);
    cyc(P2);   check("miss1_s1",  32'(score1), 1);
    check("miss1_serve", 32'(serve_side), 0);

    // Early press by p1 at bit 3: fault, point to p0.
    press_a(1'b1, 1'b0);
    cyc(12);  check("early_bit3", 32'(leds), 32'h08);
    press_a(1'b0, 1'b1);
    check("early_s0",    32'(score0), 2);
    check("early_serve", 32'(serve_side), 1);
    check("early_leds",  32'(leds), 32'h80);

    // Non-server ignored; press between ticks is remembered.
    press_a(1'b1, 1'b0);
    cyc(4);   check("nonsrv_leds", 32'(leds), 32'h80);
    tick = 1'b0;
    press_a(1'b0, 1'b1);
    cyc(3);   check("sticky_wait", 32'(leds), 32'h80);
    tick = 1'b1;
    cyc(1);
    cyc(4);   check("sticky_bit6", 32'(leds), 32'h40);
    cyc(24);  check("sticky_bit0", 32'(leds), 32'h01);
    cyc(4);   check("miss2_s1",    32'(score1), 2);
    check("miss2_serve", 32'(serve_side), 0);

    // Run p0 up to 14, then the winning point.
    press_a(1'b1, 1'b0);
    press_a(1'b0, 1'b1);
    check("s0_3", 32'(score0), 3);
    for (int i = 0; i < 11; i++) p0_point_a();
    check("s0_14", 32'({score0, score1}), 32'hE2);
    check("s0_14_go", 32'(game_over), 0);
    p0_point_a();
    check("win_s",    32'({score0, score1}), 32'hF2);
    check("win_go",   32'(game_over), 1);
    check("win_who",  32'(winner), 0);
    check("win_leds", 32'(leds), 32'hFF);
    press_a(1'b1, 1'b0);
    press_a(1'b0, 1'b1);
    press_a(1'b1, 1'b1);
    cyc(10);
    check("go_hold_s",    32'({score0, score1}), 32'hF2);
    check("go_hold_leds", 32'({game_over, leds}), 32'h1FF);
    reset = 1'b1;
    #1 check("go_rst_async", 32'(leds), 32'h01);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    check("go_rst_s",   32'({score0, score1}), 0);
    check("go_rst_flg", 32'({serve_side, game_over, winner}), 0);
    check("go_rst_led", 32'(leds), 32'h01);

    // 16-LED, first to 3.
    press_b(1'b1, 1'b0);
    press_b(1'b0, 1'b1);
    check("b_s0_1",  32'(score0_b), 1);
    check("b_end15", 32'(leds_b), 32'h8000);
    for (int i = 0; i < 2; i++) begin
      press_b(1'b0, 1'b1);
      cyc(60);
      press_b(1'b1, 1'b0);
      press_b(1'b0, 1'b1);
    end
    check("b_win_s",    32'({score0_b, score1_b}), 32'h30);
    check("b_win_go",   32'({go_b, win_b}), 32'h2);
    check("b_win_leds", 32'(leds_b), 32'hFFFF);
    reset_b = 1'b1;
    cyc(1);
    reset_b = 1'b0;
    press_b(1'b1, 1'b0);
    cyc(36);  check("b_bit9", 32'(leds_b), 32'h0200);
    reset_b = 1'b1;
    #1 check("b_mid_rst_leds", 32'(leds_b), 32'h0001);
    cyc(1);
    reset_b = 1'b0;
    cyc(2);
    check("b_mid_rst_s",    32'({score0_b, score1_b}), 0);
    check("b_mid_rst_leds2", 32'(leds_b), 32'h0001);
    check("b_mid_rst_go",   32'({serve_b, go_b, win_b}), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
